// File: rtl/tt_sweep_driver.sv
// -----------------------------------------------------------------------------
// tt_sweep_driver
//
// Purpose:
//   Stimulus and checking engine for a small combinational function block with
//   inputs a/b/c and output y. A start pulse makes it walk every input
//   combination onto out_vec. Each vector is held for SETTLE cycles and then
//   sampled for one CAPTURE cycle. Each sampled y is written into a
//   truth-table word, and that word is compared bit-by-bit against in_expect.
//
// Configuration:
//   SWEEP_GRAY_EN  - when defined, out_vec steps in reflected Gray order so that
//                    only one input toggles per step. Table and expect
//                    indexing always use the real out_vec value, so the
//                    captured table is identical to the binary build.
//                    When undefined, out_vec counts up in plain binary.
//
// Parameters:
//   N_IN    - number of function inputs (out_vec width); table width 2**N_IN
//   SETTLE  - cycles each vector is held before y is sampled (legal 1..15)
//
// Ports:
//   in_clk         clock, rising edge
//   in_rst_n       asynchronous active-low reset
//   in_start       one-cycle sweep request, honoured only when idle
//   in_y           y output of the block under drive
//   in_expect      expected truth table, bit k = y for vector k
//   out_vec        applied vector, MSB drives a, LSB drives c
//   out_busy       high from sweep start until out_done
//   out_done       one-cycle pulse at end of sweep
//   out_table      captured truth table, bit k = sampled y for vector k
//   out_err_count  number of mismatching table bits
//   out_pass       1 when the last completed sweep had zero mismatches
// -----------------------------------------------------------------------------
module tt_sweep_driver #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_start,
    input  logic                 in_y,
    input  logic [2**N_IN-1:0]   in_expect,
    output logic [N_IN-1:0]      out_vec,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [2**N_IN-1:0]   out_table,
    output logic [N_IN:0]        out_err_count,
    output logic                 out_pass
);

    localparam int TBL_W = 2**N_IN;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Maps the sweep step index onto the vector actually driven.
    function automatic logic [N_IN-1:0] vec_of_step(input logic [N_IN-1:0] step);
`ifdef SWEEP_GRAY_EN
        return step ^ (step >> 1'b1);
`else
        return step;
`endif
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    // Step index is kept separately from out_vec so the end-of-sweep test is
    // the same in binary and Gray builds (all-ones step == last vector).
    logic [N_IN-1:0]     step_r;
    logic [N_IN-1:0]     step_nxt_s;
    logic [N_IN-1:0]     vec_nxt_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic [TBL_W-1:0]    table_nxt_s;
    logic [N_IN:0]       err_nxt_s;
    logic                pass_nxt_s;
    logic                last_step_s;

    assign last_step_s = (step_r == {N_IN{1'b1}});

    // Next-state and next-output decode for the sweep FSM.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        step_nxt_s   = step_r;
        vec_nxt_s    = out_vec;
        busy_nxt_s   = out_busy;
        done_nxt_s   = 1'b0;
        table_nxt_s  = out_table;
        err_nxt_s    = out_err_count;
        pass_nxt_s   = out_pass;

        case (state_r)
            ST_IDLE: begin
                if (in_start) begin
                    table_nxt_s  = {TBL_W{1'b0}};
                    err_nxt_s    = {(N_IN+1){1'b0}};
                    step_nxt_s   = {N_IN{1'b0}};
                    vec_nxt_s    = vec_of_step({N_IN{1'b0}});
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    busy_nxt_s   = 1'b1;
                    pass_nxt_s   = 1'b0;
                    next_state_s = ST_SETTLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == SETTLE_LAST) begin
                    next_state_s = ST_CAPTURE;
                end else begin
                    next_state_s = ST_SETTLE;
                end
            end

            ST_CAPTURE: begin
                table_nxt_s[out_vec] = in_y;
                if (in_y != in_expect[out_vec]) begin
                    err_nxt_s = out_err_count + {{N_IN{1'b0}}, 1'b1};
                end else begin
                    err_nxt_s = out_err_count;
                end
                if (last_step_s) begin
                    done_nxt_s   = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    step_nxt_s   = step_r + {{(N_IN-1){1'b0}}, 1'b1};
                    vec_nxt_s    = vec_of_step(step_r + {{(N_IN-1){1'b0}}, 1'b1});
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    next_state_s = ST_SETTLE;
                end
            end

            ST_DONE: begin
                // out_err_count already holds the result of the final CAPTURE.
                busy_nxt_s   = 1'b0;
                pass_nxt_s   = (out_err_count == {(N_IN+1){1'b0}});
                next_state_s = ST_IDLE;
            end

            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            step_r        <= {N_IN{1'b0}};
            out_vec       <= {N_IN{1'b0}};
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
            out_table     <= {TBL_W{1'b0}};
            out_err_count <= {(N_IN+1){1'b0}};
            out_pass      <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            cnt_r         <= cnt_nxt_s;
            step_r        <= step_nxt_s;
            out_vec       <= vec_nxt_s;
            out_busy      <= busy_nxt_s;
            out_done      <= done_nxt_s;
            out_table     <= table_nxt_s;
            out_err_count <= err_nxt_s;
            out_pass      <= pass_nxt_s;
        end
    end

endmodule

// File: tb/tb_tt_sweep_driver.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep_driver
//
// Self-checking bench for tt_sweep_driver (N_IN=3, SETTLE=2). The function
// block y = a(b+c) + b~c + a is modelled in the bench and driven from out_vec.
// Expected sweep results are pushed to a scoreboard queue when a start is
// driven and popped when out_done appears.
// -----------------------------------------------------------------------------
module tb_tt_sweep_driver;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int TBL_W  = 8;
    localparam int LAT    = 1 + TBL_W * (SETTLE + 1);

    typedef struct packed {
        logic [7:0] tbl;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       y;
    logic [7:0] expv;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic [7:0] tbl;
    logic [3:0] err_cnt;
    logic       pass;

    int   n_checks;
    int   n_fail;
    int   y_mode;
    exp_t sb_q[$];
    exp_t exp_r;
    logic [2:0] vec_log [0:63];
    logic [2:0] ord [0:7];

    logic [7:0] obs_tbl;
    logic [3:0] obs_err;
    logic       obs_pass;
    logic       obs_busy_after;
    logic       obs_done_after;

    tt_sweep_driver #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_start      (start),
        .in_y          (y),
        .in_expect     (expv),
        .out_vec       (vec),
        .out_busy      (busy),
        .out_done      (done),
        .out_table     (tbl),
        .out_err_count (err_cnt),
        .out_pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_y(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (a & (b | c)) | (b & ~c) | a;
    endfunction

    always_comb begin
        y = 1'b0;
        if (y_mode == 0) y = model_y(vec);
    end

    function automatic exp_t predict(input int mode, input logic [7:0] e);
        exp_t r;
        logic [2:0] v;
        r.tbl = 8'h00;
        r.err = 4'd0;
        for (int k = 0; k < 8; k++) begin
            v = k[2:0];
            r.tbl[k] = (mode == 0) ? model_y(v) : 1'b0;
            if (r.tbl[k] != e[k]) r.err = r.err + 4'd1;
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    // Drives one sweep (start sampled on the next rising edge), optionally
    // re-pulses start at cycle restart_at, and returns the cycle of out_done
    // (0 on timeout). Observed results are left in obs_*.
    task automatic run_sweep(input logic [7:0] e, input int mode,
                             input int restart_at, output int dcyc);
        expv   = e;
        y_mode = mode;
        sb_q.push_back(predict(mode, e));
        start  = 1'b1;
        dcyc   = 0;
        for (int i = 1; i <= LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (i < 64) vec_log[i] = vec;
            if (i == restart_at) start = 1'b1;
            if (i == restart_at + 1) start = 1'b0;
            if (done) begin
                dcyc = i;
                break;
            end
        end
        start   = 1'b0;
        obs_tbl = tbl;
        obs_err = err_cnt;
        @(posedge clk);
        #1;
        obs_pass       = pass;
        obs_busy_after = busy;
        obs_done_after = done;
    endtask

    task automatic pop_expect(output exp_t r);
        if (sb_q.size() == 0) begin
            r = '0;
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, required >=1");
        end else begin
            r = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 6;
        if (vec !== 3'd0)     begin n_fail++; $display("FAIL reset_vec: got %0d, required 0", vec); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        if (tbl !== 8'h00)    begin n_fail++; $display("FAIL reset_table: got %h, required 00", tbl); end
        if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_err: got %0d, required 0", err_cnt); end
        if (pass !== 1'b0)    begin n_fail++; $display("FAIL reset_pass: got %b, required 0", pass); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_basic_sweep();
        int dcyc;
        run_sweep(8'hF4, 0, 0, dcyc);
        pop_expect(exp_r);
        n_checks += 7;
        if (dcyc != LAT)            begin n_fail++; $display("FAIL basic_latency: got %0d, required %0d", dcyc, LAT); end
        if (obs_tbl !== exp_r.tbl)  begin n_fail++; $display("FAIL basic_table: got %h, required %h", obs_tbl, exp_r.tbl); end
        if (obs_tbl !== 8'hF4)      begin n_fail++; $display("FAIL basic_table_const: got %h, required f4", obs_tbl); end
        if (obs_err !== exp_r.err)  begin n_fail++; $display("FAIL basic_err: got %0d, required %0d", obs_err, exp_r.err); end
        if (obs_pass !== exp_r.pass) begin n_fail++; $display("FAIL basic_pass: got %b, required %b", obs_pass, exp_r.pass); end
        if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b, required 0", obs_busy_after); end
        if (obs_done_after !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b, required 0", obs_done_after); end
    endtask

    task automatic test_vec_order();
        int dcyc;
`ifdef SWEEP_GRAY_EN
        ord = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
        ord = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        run_sweep(8'hF4, 0, 0, dcyc);
        pop_expect(exp_r);
        for (int i = 1; i <= TBL_W * (SETTLE + 1); i++) begin
            n_checks++;
            if (vec_log[i] !== ord[(i - 1) / (SETTLE + 1)]) begin
                n_fail++;
                $display("FAIL vec_order cycle %0d: got %0d, required %0d", i, vec_log[i], ord[(i - 1) / (SETTLE + 1)]);
            end
        end
        n_checks += 2;
        if (vec_log[LAT] !== ord[7]) begin n_fail++; $display("FAIL vec_hold_done: got %0d, required %0d", vec_log[LAT], ord[7]); end
        if (obs_tbl !== exp_r.tbl)  begin n_fail++; $display("FAIL order_table: got %h, required %h", obs_tbl, exp_r.tbl); end
    endtask

    task automatic test_single_mismatch();
        int dcyc;
        run_sweep(8'hF5, 0, 0, dcyc);
        pop_expect(exp_r);
        n_checks += 4;
        if (dcyc != LAT)             begin n_fail++; $display("FAIL mism1_latency: got %0d, required %0d", dcyc, LAT); end
        if (obs_tbl !== exp_r.tbl)   begin n_fail++; $display("FAIL mism1_table: got %h, required %h", obs_tbl, exp_r.tbl); end
        if (obs_err !== exp_r.err)   begin n_fail++; $display("FAIL mism1_err: got %0d, required %0d", obs_err, exp_r.err); end
        if (obs_pass !== exp_r.pass) begin n_fail++; $display("FAIL mism1_pass: got %b, required %b", obs_pass, exp_r.pass); end
    endtask

    task automatic test_all_mismatch();
        int dcyc;
        run_sweep(8'hFF, 1, 0, dcyc);
        pop_expect(exp_r);
        n_checks += 4;
        if (obs_tbl !== exp_r.tbl)   begin n_fail++; $display("FAIL mism8_table: got %h, required %h", obs_tbl, exp_r.tbl); end
        if (obs_err !== exp_r.err)   begin n_fail++; $display("FAIL mism8_err: got %0d, required %0d", obs_err, exp_r.err); end
        if (obs_err !== 4'd8)        begin n_fail++; $display("FAIL mism8_nowrap: got %0d, required 8", obs_err); end
        if (obs_pass !== exp_r.pass) begin n_fail++; $display("FAIL mism8_pass: got %b, required %b", obs_pass, exp_r.pass); end
    endtask

    task automatic test_ignored_start();
        int dcyc;
        run_sweep(8'hF4, 0, 10, dcyc);
        pop_expect(exp_r);
        n_checks += 3;
        if (dcyc != LAT)             begin n_fail++; $display("FAIL ignore_latency: got %0d, required %0d", dcyc, LAT); end
        if (obs_tbl !== exp_r.tbl)   begin n_fail++; $display("FAIL ignore_table: got %h, required %h", obs_tbl, exp_r.tbl); end
        if (obs_pass !== exp_r.pass) begin n_fail++; $display("FAIL ignore_pass: got %b, required %b", obs_pass, exp_r.pass); end
    endtask

    // Called directly after a sweep returns, i.e. in the first idle cycle.
    task automatic test_back_to_back();
        int dcyc;
        run_sweep(8'hF5, 0, 0, dcyc);
        pop_expect(exp_r);
        n_checks += 3;
        if (dcyc != LAT)             begin n_fail++; $display("FAIL b2b_latency: got %0d, required %0d", dcyc, LAT); end
        if (obs_err !== exp_r.err)   begin n_fail++; $display("FAIL b2b_err: got %0d, required %0d", obs_err, exp_r.err); end
        if (obs_pass !== exp_r.pass) begin n_fail++; $display("FAIL b2b_pass: got %b, required %b", obs_pass, exp_r.pass); end
    endtask

    task automatic test_reset_mid();
        int dcyc;
        int done_seen;
        expv      = 8'hF4;
        y_mode    = 0;
        sb_q.push_back(predict(0, 8'hF4));
        done_seen = 0;
        start     = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (done) done_seen++;
        end
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        n_checks += 6;
        if (vec !== 3'd0)     begin n_fail++; $display("FAIL midrst_vec: got %0d, required 0", vec); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (done !== 1'b0)    begin n_fail++; $display("FAIL midrst_done: got %b, required 0", done); end
        if (tbl !== 8'h00)    begin n_fail++; $display("FAIL midrst_table: got %h, required 00", tbl); end
        if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_err: got %0d, required 0", err_cnt); end
        if (pass !== 1'b0)    begin n_fail++; $display("FAIL midrst_pass: got %b, required 0", pass); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses, required 0", done_seen); end
        run_sweep(8'hF4, 0, 0, dcyc);
        pop_expect(exp_r);
        n_checks += 3;
        if (dcyc != LAT)             begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d, required %0d", dcyc, LAT); end
        if (obs_tbl !== exp_r.tbl)   begin n_fail++; $display("FAIL midrst_fresh_table: got %h, required %h", obs_tbl, exp_r.tbl); end
        if (obs_pass !== exp_r.pass) begin n_fail++; $display("FAIL midrst_fresh_pass: got %b, required %b", obs_pass, exp_r.pass); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        expv     = 8'h00;
        y_mode   = 0;
        test_reset();
        test_basic_sweep();
        test_vec_order();
        test_single_mismatch();
        test_all_mismatch();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
